result_checker_fsm: RTL and testbench
=====================================

Name: result_checker_fsm

Overview:
- Sequential self-checking initiator for the 4-input single-output decode block (F = 1 exactly for ABCD in {0001, 0011, 1001, 1011}).
- On `start`, drives all 16 ABCD codes in ascending order onto the unit under check and waits a programmable settle time per code.
- Samples the returned F, compares it against a parameterised expected truth table, and accumulates pass/fail counts and the first failing code.
- Sits beside the decoder as the stimulus/check end of the same ABCD -> F interface, replacing the hand-written directed bench with synthesizable hardware.

Parameters:
- SETTLE_CYCLES, 1, cycles `abcd_out` is held before `f_in` is sampled; legal range 1..15. 0 is illegal; elaboration must fail.
- EXPECT_MASK, 16'h0A0A, expected F per code; bit n = expected F for ABCD == n (bits 1, 3, 9, 11 set).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- abcd_out  output  4  stimulus code to the unit under check
- f_in  input  1  F returned by the unit under check
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  level; 1 when the last completed run had zero mismatches
- pass_count  output  5  matched codes in the current/last run (0..16)
- fail_count  output  5  mismatched codes in the current/last run (0..16)
- first_fail_valid  output  1  at least one mismatch has occurred in the current/last run
- first_fail_code  output  4  ABCD of the first mismatch; valid only when `first_fail_valid` = 1

Behaviour:
- Reset: `rst_n` = 0 at a rising edge forces the following.
  - State = IDLE.
  - `abcd_out` = 0, `busy` = 0, `done` = 0, `pass` = 0.
  - `pass_count` = 0, `fail_count` = 0, `first_fail_valid` = 0, `first_fail_code` = 0.
  - Reset takes priority over every other event. Reset mid-run aborts the run immediately with no `done` pulse.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with `start` = 1 at an edge:
  - Next state SETTLE.
  - `abcd_out` = 0; settle counter loaded.
  - Counters, `first_fail_*` and `pass` cleared.
  - `busy` = 1 from that edge.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles with `abcd_out` stable, then moves to CHECK.
- CHECK:
  - Lasts 1 cycle.
  - At its closing edge, `f_in` is compared with EXPECT_MASK[`abcd_out`].
  - Match: `pass_count` += 1.
  - Mismatch: `fail_count` += 1. If `first_fail_valid` = 0, set `first_fail_valid` = 1 and `first_fail_code` = `abcd_out`.
  - If `abcd_out` < 15: `abcd_out` += 1, counter reloaded, next state SETTLE.
  - If `abcd_out` == 15: next state DONE, `busy` = 0, `done` = 1 for exactly one cycle, `pass` = (final `fail_count` == 0).
  - The final compare must be included in the `pass` decision.
- Timing:
  - Per-code period is SETTLE_CYCLES + 1 cycles.
  - The `done` pulse is high in the cycle starting 16*(SETTLE_CYCLES+1) edges after the `start` edge.
  - `f_in` is sampled SETTLE_CYCLES+1 edges after `abcd_out` changes. A unit with registered latency L passes iff L <= SETTLE_CYCLES.
- Held results: in DONE, `abcd_out` holds 15 and all result outputs hold until the next `start` or reset.
- `start` while busy (SETTLE/CHECK) is ignored, with no restart and no counter effect.
- Counters never wrap: the maximum is 16, and `pass_count` + `fail_count` == number of CHECK states completed.
- `f_in` is used only in CHECK; X or changes on `f_in` outside CHECK have no effect.

Test Plan:
- SETTLE_CYCLES = 1, `f_in` driven by a correct combinational decoder, pulse `start` -> `abcd_out` steps 0..15 every 2 cycles; `done` pulses 32 cycles after start; `pass` = 1, `pass_count` = 16, `fail_count` = 0, `first_fail_valid` = 0.
- `f_in` tied 0 -> `fail_count` = 4, `pass_count` = 12, `first_fail_code` = 4'b0001, `pass` = 0. `f_in` tied 1 -> `fail_count` = 12, `pass_count` = 4, `first_fail_code` = 4'b0000.
- Decoder with 2-cycle registered latency: SETTLE_CYCLES = 1 -> `fail_count` > 0, `pass` = 0; SETTLE_CYCLES = 2 -> `pass` = 1, `pass_count` = 16, `done` at 48 cycles.
- Assert `rst_n` = 0 while `abcd_out` = 5 -> next cycle IDLE, all outputs 0, no `done` pulse; then `start` -> full clean run, `pass` = 1.
- `start` held high for the whole run -> single run, counts total 16, `done` pulses once, and a new run begins at the DONE-state edge. A second `start` after DONE clears the previous results before the new run begins.

Source files
------------

// File: rtl/result_checker_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_checker_fsm : walks ABCD 0..15 into a decoder, samples F after a
//                      programmable settle time and tallies pass/fail results.
// Revision 1.0
// ---------------------------------------------------------------------------
module result_checker_fsm #(
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXPECT_MASK   = 16'h0A0A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] abcd_out,
  input  logic       f_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] pass_count,
  output logic [4:0] fail_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_code
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("SETTLE_CYCLES must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [3:0] abcd_nxt;
  logic       done_nxt;
  logic       pass_nxt;
  logic [4:0] pass_count_nxt;
  logic [4:0] fail_count_nxt;
  logic       ffv_nxt;
  logic [3:0] ffc_nxt;
  logic       match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle_cnt       <= 4'd0;
      abcd_out         <= 4'd0;
      done             <= 1'b0;
      pass             <= 1'b0;
      pass_count       <= 5'd0;
      fail_count       <= 5'd0;
      first_fail_valid <= 1'b0;
      first_fail_code  <= 4'd0;
    end else begin
      state            <= state_nxt;
      settle_cnt       <= settle_cnt_nxt;
      abcd_out         <= abcd_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
      pass_count       <= pass_count_nxt;
      fail_count       <= fail_count_nxt;
      first_fail_valid <= ffv_nxt;
      first_fail_code  <= ffc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    abcd_nxt       = abcd_out;
    done_nxt       = 1'b0;
    pass_nxt       = pass;
    pass_count_nxt = pass_count;
    fail_count_nxt = fail_count;
    ffv_nxt        = first_fail_valid;
    ffc_nxt        = first_fail_code;
    match          = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = SETTLE_LOAD;
          abcd_nxt       = 4'd0;
          pass_nxt       = 1'b0;
          pass_count_nxt = 5'd0;
          fail_count_nxt = 5'd0;
          ffv_nxt        = 1'b0;
          ffc_nxt        = 4'd0;
        end
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_nxt = CHECK;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      CHECK: begin
        match = (f_in == EXPECT_MASK[abcd_out]);
        if (match) begin
          pass_count_nxt = pass_count + 5'd1;
        end else begin
          fail_count_nxt = fail_count + 5'd1;
          if (!first_fail_valid) begin
            ffv_nxt = 1'b1;
            ffc_nxt = abcd_out;
          end
        end
        if (abcd_out != 4'd15) begin
          abcd_nxt       = abcd_out + 4'd1;
          settle_cnt_nxt = SETTLE_LOAD;
          state_nxt      = SETTLE;
        end else begin
          // The last compare has to take part in the verdict.
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = match && (fail_count == 5'd0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SETTLE) || (state == CHECK);

endmodule
`default_nettype wire

// File: tb/tb_result_checker_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_result_checker_fsm : scoreboard bench for result_checker_fsm.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_result_checker_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  int         mode_a  = 0;
  logic       sel     = 1'b0;

  logic       f_a, f_b;
  logic [3:0] a_abcd, b_abcd, a_ffc, b_ffc;
  logic       a_busy, a_done, a_pass, a_ffv;
  logic       b_busy, b_done, b_pass, b_ffv;
  logic [4:0] a_pc, a_fc, b_pc, b_fc;
  logic       la1 = 1'b0, la2 = 1'b0, lb1 = 1'b0, lb2 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic pass;
    int   pc;
    int   fc;
    logic ffv;
    int   ffc;
    int   cycles;
  } exp_t;

  exp_t sb[$];

  result_checker_fsm #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abcd_out(a_abcd), .f_in(f_a),
    .busy(a_busy), .done(a_done), .pass(a_pass), .pass_count(a_pc),
    .fail_count(a_fc), .first_fail_valid(a_ffv), .first_fail_code(a_ffc)
  );

  result_checker_fsm #(.SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abcd_out(b_abcd), .f_in(f_b),
    .busy(b_busy), .done(b_done), .pass(b_pass), .pass_count(b_pc),
    .fail_count(b_fc), .first_fail_valid(b_ffv), .first_fail_code(b_ffc)
  );

  // Reference decoder: F = D & ~B
  function automatic logic ref_f(input logic [3:0] c);
    return c[0] & ~c[2];
  endfunction

  // Two-stage registered decoders
  always @(posedge clk) begin
    la1 <= ref_f(a_abcd);
    la2 <= la1;
    lb1 <= ref_f(b_abcd);
    lb2 <= lb1;
  end

  always_comb begin
    case (mode_a)
      0:       f_a = ref_f(a_abcd);
      1:       f_a = 1'b0;
      2:       f_a = 1'b1;
      default: f_a = la2;
    endcase
  end
  assign f_b = lb2;

  logic [3:0] o_abcd, o_ffc;
  logic       o_busy, o_done, o_pass, o_ffv;
  logic [4:0] o_pc, o_fc;
  always_comb begin
    o_abcd = sel ? b_abcd : a_abcd;
    o_ffc  = sel ? b_ffc  : a_ffc;
    o_busy = sel ? b_busy : a_busy;
    o_done = sel ? b_done : a_done;
    o_pass = sel ? b_pass : a_pass;
    o_ffv  = sel ? b_ffv  : a_ffv;
    o_pc   = sel ? b_pc   : a_pc;
    o_fc   = sel ? b_fc   : a_fc;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int mode, input int s, input int prev);
    exp_t e;
    int   got, want;
    e.pc = 0; e.fc = 0; e.ffv = 1'b0; e.ffc = 0;
    for (int n = 0; n < 16; n++) begin
      want = ref_f(4'(n));
      case (mode)
        0:       got = want;
        1:       got = 0;
        2:       got = 1;
        default: got = (s >= 2) ? want : ref_f(4'((n == 0) ? prev : n - 1));
      endcase
      if (got == want) e.pc++;
      else begin
        e.fc++;
        if (!e.ffv) begin
          e.ffv = 1'b1;
          e.ffc = n;
        end
      end
    end
    e.pass   = (e.fc == 0);
    e.cycles = 16 * (s + 1);
    return e;
  endfunction

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, o_busy, 1);
    chk({tag, "_abcd"}, o_abcd, 0);
    chk({tag, "_pc"},   o_pc,   0);
    chk({tag, "_fc"},   o_fc,   0);
    chk({tag, "_ffv"},  o_ffv,  0);
    chk({tag, "_pass"}, o_pass, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  task automatic start_run(input logic s, input int mode, input bit hold, input bit push);
    int prev;
    @(negedge clk);
    sel    = s;
    mode_a = mode;
    prev   = o_abcd;
    if (push) sb.push_back(model(mode, s ? 2 : 1, prev));
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    check_cleared("start");
  endtask

  task automatic wait_done(input int s, input bit hold);
    int   k;
    bit   got;
    int   held_pc;
    exp_t e;
    k = 0; got = 0;
    while (k < 16 * (s + 1) + 4) begin
      if (o_done) begin
        got = 1;
        break;
      end
      if ((k % (s + 1)) == 0 && k < 16 * (s + 1)) begin
        chk("abcd_step", o_abcd, k / (s + 1));
        chk("busy_run", o_busy, 1);
      end
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      chk("done_timeout", 0, 1);
      return;
    end
    chk("done_cycles", k, e.cycles);
    chk("pass", o_pass, e.pass);
    chk("pass_count", o_pc, e.pc);
    chk("fail_count", o_fc, e.fc);
    chk("ffv", o_ffv, e.ffv);
    if (e.ffv) chk("ffc", o_ffc, e.ffc);
    chk("busy_done", o_busy, 0);
    chk("abcd_last", o_abcd, 15);
    held_pc = o_pc;
    @(posedge clk); #1;
    chk("done_pulse_len", o_done, 0);
    if (hold) begin
      // Start still high in DONE: a fresh run begins at this edge.
      sb.push_back(model(mode_a, s, 15));
      check_cleared("restart");
      start_a = 1'b0;
      start_b = 1'b0;
    end else begin
      chk("held_pc", o_pc, held_pc);
      chk("held_abcd", o_abcd, 15);
      chk("held_pass", o_pass, e.pass);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    bit any_done;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_abcd", a_abcd, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_fc", a_fc, 0);
    chk("rst_ffv", a_ffv, 0);
    chk("rst_ffc", a_ffc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start_run(1'b0, 0, 1'b0, 1'b1); wait_done(1, 1'b0);  // correct decoder
    start_run(1'b0, 1, 1'b0, 1'b1); wait_done(1, 1'b0);  // F tied 0
    start_run(1'b0, 2, 1'b0, 1'b1); wait_done(1, 1'b0);  // F tied 1
    start_run(1'b0, 3, 1'b0, 1'b1); wait_done(1, 1'b0);  // latency 2, settle 1
    start_run(1'b1, 3, 1'b0, 1'b1); wait_done(2, 1'b0);  // latency 2, settle 2

    // Reset mid-run
    start_run(1'b0, 0, 1'b0, 1'b0);
    waited = 0;
    while (a_abcd != 4'd5 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("reach_code5", a_abcd, 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_abcd", a_abcd, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_pc", a_pc, 0);
    chk("abort_fc", a_fc, 0);
    chk("abort_ffv", a_ffv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    any_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_done || a_busy) any_done = 1;
    end
    chk("abort_quiet", any_done, 0);
    start_run(1'b0, 0, 1'b0, 1'b1); wait_done(1, 1'b0);

    // Start held high through the run
    start_run(1'b0, 0, 1'b1, 1'b1); wait_done(1, 1'b1);
    wait_done(1, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
